// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock monitor.
package clk_mon_pkg;

  // Default width of the period/high-time counters and measurement outputs.
  localparam int DEF_CNT_W = 16;

  // Measurement FSM: IDLE until the first rising edge, then alternates
  // HIGH/LOW following the monitored clock's level.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } mon_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input with registered
// single-cycle rise/fall strobes. Reusable for any slow async level.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic synced,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  assign synced = chain[SYNC_STAGES-1];

  // Shift the async level through the chain and register edge strobes from
  // the synchronized level versus its one-cycle-delayed copy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a slow divided clock in clk cycles,
// compares each full period against the expected values and tracks lock.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam int               MC_W      = $clog2(LOCK_CNT + 1);
  localparam logic [MC_W-1:0]  LOCK_V    = MC_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  logic             rise;
  logic             fall;
  logic             sync_level_unused;
  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] hi_lat;
  logic [MC_W-1:0]  match_cnt;
  logic [MC_W-1:0]  match_inc;
  logic             is_match;
  logic             stalled;
  mon_state_t       state;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(sig_in),
    .synced  (sync_level_unused),
    .rise    (rise),
    .fall    (fall)
  );

  // Saturating successor of the match counter, the exact-compare result for
  // the period being closed, and the loss-of-signal condition.
  always_comb begin
    if (match_cnt == LOCK_V) begin
      match_inc = LOCK_V;
    end else begin
      match_inc = match_cnt + MC_W'(1);
    end
    is_match = (per_cnt == exp_period) && (hi_lat == exp_high);
    // >= rather than == so a fall landing exactly on the limit cannot let
    // the counter slip past it and silence the timeout.
    stalled  = (per_cnt >= TIMEOUT_V);
  end

  // Period counter: restarts at 1 on each rising edge so that at the next
  // rise it holds the full period length.
  always_ff @(posedge clk) begin
    if (!rst) begin
      per_cnt <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
    end else begin
      per_cnt <= per_cnt + CNT_W'(1);
    end
  end

  // High-time capture: the period count at the falling edge is the high time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_lat <= '0;
    end else if (fall) begin
      hi_lat <= per_cnt;
    end else begin
      hi_lat <= hi_lat;
    end
  end

  // Measurement FSM with registered publish, match/lock and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
      match_cnt   <= '0;
    end else begin
      meas_valid <= 1'b0;
      mismatch   <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // First period after reset or loss of signal is partial: no publish.
          if (rise) begin
            state <= HIGH;
          end else begin
            state <= IDLE;
          end
        end
        HIGH: begin
          if (fall) begin
            state <= LOW;
          end else if (stalled) begin
            state     <= IDLE;
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end else begin
            state <= HIGH;
          end
        end
        LOW: begin
          if (rise) begin
            state       <= HIGH;
            meas_valid  <= 1'b1;
            meas_period <= per_cnt;
            meas_high   <= hi_lat;
            if (is_match) begin
              match_cnt <= match_inc;
              locked    <= (match_inc == LOCK_V);
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
              mismatch  <= 1'b1;
            end
          end else if (stalled) begin
            state     <= IDLE;
            timeout   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end else begin
            state <= LOW;
          end
        end
        default: begin
          state     <= IDLE;
          locked    <= 1'b0;
          match_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: an edge-time reference model pushes
// expected publications/timeouts; a monitor pops them when the DUT pulses.
module tb_clk_div_monitor;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int LOCK  = 4;
  localparam int TMO   = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] exp_period = 16'd12;
  logic [CNT_W-1:0] exp_high = 16'd6;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  clk_div_monitor #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .exp_period(exp_period), .exp_high(exp_high),
    .meas_valid(meas_valid), .meas_period(meas_period), .meas_high(meas_high),
    .locked(locked), .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_to;
    int at;
    int per;
    int hi;
    bit mm;
    bit lk;
  } ev_t;

  ev_t q[$];
  ev_t got;
  int  errors = 0;
  int  checks = 0;

  // Reference model: works on the sequence of sampled input levels and the
  // edge times within it; outputs appear SYNC+1 edges after the sample edge.
  bit m_prev = 1'b0;
  bit m_armed = 1'b0;
  int m_rise = 0;
  int m_fall = 0;
  int m_mc = 0;
  bit m_lk = 1'b0;
  int rst_chk_at = -1;

  function automatic void model_step(bit b, int n);
    ev_t e;
    bit  r;
    bit  f;
    r = b & ~m_prev;
    f = ~b & m_prev;
    m_prev = b;
    if (r) begin
      if (m_armed) begin
        e.is_to = 1'b0;
        e.at  = n + SYNC + 1;
        e.per = n - m_rise;
        e.hi  = m_fall - m_rise;
        if (e.per == int'(exp_period) && e.hi == int'(exp_high)) begin
          m_mc = (m_mc < LOCK) ? m_mc + 1 : LOCK;
          m_lk = (m_mc == LOCK);
          e.mm = 1'b0;
        end else begin
          m_mc = 0;
          m_lk = 1'b0;
          e.mm = 1'b1;
        end
        e.lk = m_lk;
        q.push_back(e);
      end
      m_armed = 1'b1;
      m_rise = n;
    end else begin
      if (f) m_fall = n;
      if (m_armed && (n - m_rise) == TMO) begin
        e.is_to = 1'b1;
        e.at = n + SYNC + 1;
        e.per = 0;
        e.hi = 0;
        e.mm = 1'b0;
        e.lk = 1'b0;
        q.push_back(e);
        m_armed = 1'b0;
        m_mc = 0;
        m_lk = 1'b0;
      end
    end
  endfunction

  // One clk cycle of stimulus: level b sampled at the next rising edge, r=0 resets.
  task automatic drive(bit b, bit r);
    @(negedge clk);
    sig_in = b;
    rst = r;
    if (!r) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL pending_at_reset: %0d events outstanding, need 0", q.size());
      end
      q.delete();
      m_prev = 1'b0;
      m_armed = 1'b0;
      m_mc = 0;
      m_lk = 1'b0;
      rst_chk_at = cyc + 1;
    end else begin
      model_step(b, cyc + 1);
    end
  endtask

  task automatic seg(int h, int l);
    for (int i = 0; i < h; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < l; i++) drive(1'b0, 1'b1);
  endtask

  // Let any in-flight publish complete before the expected values change.
  task automatic set_exp(int p, int h);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
    exp_period = CNT_W'(p);
    exp_high = CNT_W'(h);
  endtask

  // Monitor: reset-state check, mismatch alignment, and scoreboard compare.
  always @(negedge clk) begin
    if (rst_chk_at == cyc) begin
      checks++;
      if (meas_valid || mismatch || timeout || locked ||
          meas_period != 16'd0 || meas_high != 16'd0) begin
        errors++;
        $display("FAIL reset_state: valid=%0b mm=%0b to=%0b lk=%0b per=%0d hi=%0d, need all 0",
                 meas_valid, mismatch, timeout, locked, meas_period, meas_high);
      end
    end
    if (mismatch) begin
      checks++;
      if (!meas_valid) begin
        errors++;
        $display("FAIL mismatch_align: mismatch without meas_valid at cycle %0d", cyc);
      end
    end
    if (meas_valid || timeout) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: valid=%0b to=%0b at cycle %0d, none expected",
                 meas_valid, timeout, cyc);
      end else begin
        got = q.pop_front();
        if (got.is_to) begin
          if (!timeout || meas_valid || locked || cyc != got.at) begin
            errors++;
            $display("FAIL timeout_event: to=%0b valid=%0b lk=%0b cyc=%0d, need to=1 valid=0 lk=0 cyc=%0d",
                     timeout, meas_valid, locked, cyc, got.at);
          end
        end else begin
          if (!meas_valid || timeout || cyc != got.at || int'(meas_period) != got.per ||
              int'(meas_high) != got.hi || mismatch != got.mm || locked != got.lk) begin
            errors++;
            $display("FAIL measurement: valid=%0b to=%0b cyc=%0d per=%0d hi=%0d mm=%0b lk=%0b, need valid=1 to=0 cyc=%0d per=%0d hi=%0d mm=%0b lk=%0b",
                     meas_valid, timeout, cyc, meas_period, meas_high, mismatch, locked,
                     got.at, got.per, got.hi, got.mm, got.lk);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit dv;
    int sc;
    int ec;
    // Reset, then nominal 6/6 with lock building up.
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) seg(6, 6);
    // One long-low period breaks lock, then relock.
    seg(6, 7);
    for (int i = 0; i < 6; i++) seg(6, 6);
    // Loss of signal while locked, then resume.
    for (int i = 0; i < 1100; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) seg(6, 6);
    // Reset mid-high while locked.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) seg(6, 6);
    // Fastest rate.
    set_exp(4, 2);
    for (int i = 0; i < 10; i++) seg(2, 2);
    // Randomized periods around nominal.
    set_exp(12, 6);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3, 0) != 0) seg(6, 6);
      else seg($urandom_range(9, 2), $urandom_range(9, 2));
    end
    // /3 divider on a clk/4 source: toggles every 3 source edges.
    dv = 1'b1;
    sc = 0;
    ec = 0;
    for (int i = 0; i < 12 * 12; i++) begin
      drive(dv, 1'b1);
      sc++;
      if (sc == 2) begin
        sc = 0;
        ec++;
        if (ec == 3) begin
          ec = 0;
          dv = ~dv;
        end
      end
    end
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, need 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measures the period and high time of a slow, divided clock (e.g. the odd-ratio divider output) in units of the fast system clock `clk`. Each full period is reported, compared against the expected period and high time, and used to drive a lock indicator. It is the checking end of the clock-divider path: it is used on-chip as a health monitor and in benches as a self-checking receiver for divider outputs.

## Interface
- `CNT_W`, 16: width of counters and measurement outputs.
- `SYNC_STAGES`, 2: synchronizer depth for `sig_in`; must be ≥2.
- `LOCK_CNT`, 4: consecutive matching periods required to assert `locked`.
- `TIMEOUT`, 1024: clk cycles without an edge before the monitor declares loss of signal; must be < 2**CNT_W.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `sig_in`, in, 1: monitored divided clock; asynchronous to `clk`.
- `exp_period`, in, CNT_W: expected period in clk cycles; quasi-static.
- `exp_high`, in, CNT_W: expected high time in clk cycles; quasi-static.
- `meas_valid`, out, 1: one-cycle pulse when a new measurement is published.
- `meas_period`, out, CNT_W: last measured period; held between pulses.
- `meas_high`, out, CNT_W: last measured high time; held between pulses.
- `locked`, out, 1: high once LOCK_CNT consecutive measurements have matched.
- `mismatch`, out, 1: one-cycle pulse, coincident with `meas_valid`, when a measurement differs from expected.
- `timeout`, out, 1: one-cycle pulse on loss of signal.

## Operation
- `sig_in` passes through a SYNC_STAGES flop chain. `rise` = synced & ~prev and `fall` = ~synced & prev, where prev is synced delayed by one clk. `rise` and `fall` are mutually exclusive.
- `per_cnt` is set to 1 on `rise` and otherwise increments by 1 every cycle. `hi_lat` latches `per_cnt` on `fall`.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: ignores `fall`. On `rise` → HIGH. No publish, because the first period is partial.
  - HIGH: on `fall` → LOW and latch `hi_lat`.
  - LOW: on `rise` → HIGH and publish: `meas_period`←`per_cnt`, `meas_high`←`hi_lat`, `meas_valid`=1.
  - HIGH/LOW: if `per_cnt` reaches TIMEOUT with no edge → IDLE, `timeout`=1, `locked`←0, `match_cnt`←0. The published values are kept.
- Match logic at publish:
  - If period == `exp_period` and high == `exp_high`: `match_cnt` increments and saturates at LOCK_CNT.
  - Otherwise: `match_cnt`←0, `locked`←0, `mismatch`=1.
  - `locked` = (`match_cnt` == LOCK_CNT), registered.
- Comparisons are exact and unsigned. A period of 1 or high time of 0 cannot occur, since the synchronizer filters these out.
- Reset values: every output 0, `match_cnt`=0, `per_cnt`=0, state IDLE. Reset mid-measurement discards the partial period, and the first period after reset is never published.

## Timing
- `sig_in` first sampled high at clk edge k: `rise` is seen at edge k+SYNC_STAGES. `meas_valid`, `meas_*`, `mismatch` and `locked` update at edge k+SYNC_STAGES+1.
- Measurement latency is constant, so `meas_period` equals the true period in clk cycles for a clean input, with ±1 jitter for asynchronous `sig_in`.
- `locked` rises in the same cycle as the LOCK_CNT-th matching `meas_valid`. It falls in the same cycle as a `mismatch` or `timeout` pulse.
- `timeout` fires at the edge where `per_cnt` == TIMEOUT, i.e. TIMEOUT cycles after the last edge. It does not repeat while in IDLE.

## Structure
- Package `clk_mon_pkg`: state enum `mon_state_t` {IDLE, HIGH, LOW} and default `CNT_W`.
- Sub-module `sync_edge_det` (parameter SYNC_STAGES; outputs synced, rise, fall). It is reusable for other async inputs.
- The top holds the FSM, `per_cnt`, `hi_lat`, match/lock logic and output registers.

## Test plan
- Reset, then `sig_in` high 6 / low 6 clk repeatedly with `exp_period`=12 and `exp_high`=6 → first period unpublished; every `meas_valid` shows 12/6; `locked`=1 on the 4th pulse; `mismatch` never fires.
- Locked at 12/6, then one period of high 6 / low 7 → `meas_period`=13, `mismatch` pulse, `locked`→0 in the same cycle; relocks after 4 further good periods.
- Hold `sig_in` low for 1100 cycles while locked → `timeout` pulses once at 1024 cycles after the last edge, `locked`=0, no `meas_valid`; resume toggling → first period discarded, then 12/6 again.
- Assert `rst` low for 1 cycle mid-HIGH while locked → all outputs 0 the next cycle; first post-reset period unpublished.
- Fast-rate stress: high 2 / low 2 → 4/2 measured; `rise` to `meas_valid` latency is exactly SYNC_STAGES+1 cycles from the sampling edge.
- Divider check: drive `sig_in` from the /3 divider clocked by a clk/4 source (high 6 / low 6) → 12/6 and locked.
